// File: rtl/const_mult_pipe_pkg.sv
// Shared constants and helpers for the pipelined constant multiplier.
// Imported by the multiplier top and its shift-add tree.
package const_mult_pkg;

    localparam int CMP_LATENCY = 3;

    localparam bit RND_TRUNC   = 1'b0;
    localparam bit RND_HALF_UP = 1'b1;
    localparam bit SAT_WRAP    = 1'b0;
    localparam bit SAT_CLAMP   = 1'b1;

    // Largest result magnitude representable in w-bit two's complement for the given sign.
    function automatic logic [32:0] sat_limit(input int w, input logic sign);
        logic [32:0] lim;
        lim = 33'd1 << (w - 1);
        if (!sign) begin
            lim = lim - 33'd1;
        end
        return lim;
    endfunction

endpackage

// File: rtl/const_mult_pipe_if.sv
// Valid/ready sample stream in and out of the constant multiplier.
// The master side drives samples and downstream ready; the slave side is the multiplier.
interface const_mult_pipe_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_sat;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/const_mult_pipe_shift_add_tree.sv
// Unsigned magnitude times a fixed constant, as a balanced adder tree of shifted copies.
// Leaves for zero constant bits are tied off and fold away; an all-zero constant builds no adders.
module shift_add_tree
    import const_mult_pkg::*;
#(
    parameter int                    DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] CONST      = '0
) (
    input  logic [DATA_WIDTH-1:0]   mag,
    output logic [2*DATA_WIDTH-1:0] prod
);
    localparam int PW = 2 * DATA_WIDTH;

    if (CONST == '0) begin : g_zero
        logic unused_mag;
        assign unused_mag = ^mag;
        assign prod       = '0;
    end else begin : g_tree
        localparam int LEVELS = $clog2(DATA_WIDTH);
        localparam int LEAVES = 1 << LEVELS;

        for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
            logic [PW-1:0] node [LEAVES >> l];
            if (l == 0) begin : g_leaves
                for (genvar k = 0; k < LEAVES; k++) begin : g_leaf
                    if (k < DATA_WIDTH) begin : g_bit
                        if (CONST[k]) begin : g_on
                            assign node[k] = {{DATA_WIDTH{1'b0}}, mag} << k;
                        end else begin : g_off
                            assign node[k] = '0;
                        end
                    end else begin : g_pad
                        assign node[k] = '0;
                    end
                end
            end else begin : g_sum
                for (genvar j = 0; j < (LEAVES >> l); j++) begin : g_add
                    assign node[j] = g_lvl[l-1].node[2*j] + g_lvl[l-1].node[2*j+1];
                end
            end
        end

        assign prod = g_lvl[LEVELS].node[0];
    end
endmodule

// File: rtl/const_mult_pipe.sv
// Three-stage signed-by-constant multiplier: sign/magnitude, shift-add product, round and clamp.
// Each stage advances when its slot is empty or the next stage advances, so bubbles collapse.
module const_mult_pipe
    import const_mult_pkg::*;
#(
    parameter int                    DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] CONST      = '0,
    parameter bit                    CONST_NEG  = 1'b0,
    parameter int                    FRAC_BITS  = 15,
    parameter bit                    ROUND      = RND_HALF_UP,
    parameter bit                    SATURATE   = SAT_CLAMP
) (
    input logic              clk,
    input logic              rst_n,
    const_mult_pipe_if.slave bus
);
    localparam int W  = DATA_WIDTH;
    localparam int PW = 2 * W + 1;
    localparam int RND_POS = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;
    localparam logic [PW-1:0] RND_ADD =
        (ROUND == RND_HALF_UP && FRAC_BITS > 0) ? (PW'(1) << RND_POS) : '0;

    logic           en1, en2, en3;
    logic           v1, v2, v3;
    logic           in_sign;
    logic [W-1:0]   in_mag;
    logic           s1_sign;
    logic [W-1:0]   s1_mag;
    logic [2*W-1:0] prod;
    logic           s2_sign;
    logic [2*W-1:0] s2_prod;
    logic [PW-1:0]  rounded;
    logic [PW-1:0]  r;
    logic [PW-1:0]  limit;
    logic [W-1:0]   res;
    logic           res_sat;
    logic [W-1:0]   s3_data;
    logic           s3_sat;

    assign en3          = !v3 || bus.out_ready;
    assign en2          = !v2 || en3;
    assign en1          = !v1 || en2;
    assign bus.in_ready = en1;

    assign bus.out_valid = v3;
    assign bus.out_data  = s3_data;
    assign bus.out_sat   = s3_sat;

    // Most negative input maps to 2^(W-1), which still fits the unsigned W-bit magnitude.
    assign in_sign = bus.in_data[W-1] ^ CONST_NEG;
    assign in_mag  = bus.in_data[W-1] ? (~bus.in_data + W'(1)) : bus.in_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1      <= 1'b0;
            s1_sign <= 1'b0;
            s1_mag  <= '0;
        end else if (en1) begin
            v1 <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sign <= in_sign;
                s1_mag  <= in_mag;
            end
        end
    end

    shift_add_tree #(
        .DATA_WIDTH (W),
        .CONST      (CONST)
    ) u_tree (
        .mag  (s1_mag),
        .prod (prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2      <= 1'b0;
            s2_sign <= 1'b0;
            s2_prod <= '0;
        end else if (en2) begin
            v2 <= v1;
            if (v1) begin
                s2_sign <= s1_sign;
                s2_prod <= prod;
            end
        end
    end

    // A zero rescaled magnitude negates to zero and never exceeds the limit, so no -0 or flag.
    always_comb begin
        rounded = {1'b0, s2_prod} + RND_ADD;
        r       = rounded >> FRAC_BITS;
        limit   = PW'(sat_limit(W, s2_sign));
        res     = s2_sign ? (W'(0) - r[W-1:0]) : r[W-1:0];
        res_sat = 1'b0;
        if (SATURATE == SAT_CLAMP && r > limit) begin
            res     = s2_sign ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            res_sat = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3      <= 1'b0;
            s3_data <= '0;
            s3_sat  <= 1'b0;
        end else if (en3) begin
            v3 <= v2;
            if (v2) begin
                s3_data <= res;
                s3_sat  <= res_sat;
            end
        end
    end
endmodule
